// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared types and constants for the voice allocator
package voice_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic [1:0] wave_t;

    // Encodings shared with get_waveform in the mixer
    localparam wave_t WAVE_SQUARE   = 2'd0;
    localparam wave_t WAVE_SAW      = 2'd1;
    localparam wave_t WAVE_TRIANGLE = 2'd2;
    localparam wave_t WAVE_SINE     = 2'd3;

    localparam int PITCH_ZERO = 0;

endpackage

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note-event handshake between event sources and the voice allocator
interface voice_allocator_if #(
    parameter int PITCH_W = 12
) ();
    import voice_pkg::*;

    logic               ev_valid;
    logic               ev_ready;
    logic               ev_on;
    logic [PITCH_W-1:0] ev_pitch;
    wave_t              ev_wave;

    modport master (output ev_valid, ev_on, ev_pitch, ev_wave, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_pitch, ev_wave, output ev_ready);

endinterface

// File: rtl/voice_oldest_finder.sv
// rtl/voice_oldest_finder.sv - max-age search over all channels, lowest index wins ties
module voice_oldest_finder #(
    parameter int NUM_CHANNELS = 25,
    parameter int AGE_W        = 8
) (
    input  logic [NUM_CHANNELS-1:0][AGE_W-1:0]   i_ages,
    output logic [$clog2(NUM_CHANNELS)-1:0]      o_idx
);
    localparam int IDX_W = $clog2(NUM_CHANNELS);

    logic [AGE_W-1:0] w_best;

    // Strict greater-than keeps the earlier index on equal ages
    always_comb begin
        w_best = i_ages[0];
        o_idx  = '0;
        for (int i = 1; i < NUM_CHANNELS; i++) begin
            if (i_ages[i] > w_best) begin
                w_best = i_ages[i];
                o_idx  = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - voice scheduler mapping note events onto mixer channels (VOICE_STEAL_EN: steal oldest voice when full)
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_CHANNELS = 25,
    parameter int PITCH_W      = 12,
    parameter int AGE_W        = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    voice_allocator_if.slave                   ev,
    input  logic                               all_off,
    output logic [NUM_CHANNELS-1:0]            channel_ena,
    output logic [NUM_CHANNELS*PITCH_W-1:0]    pitches,
    output logic [NUM_CHANNELS*2-1:0]          waveforms,
    output logic [$clog2(NUM_CHANNELS+1)-1:0]  active_count,
    output logic                               overflow
);
    localparam int IDX_W = $clog2(NUM_CHANNELS);
    localparam int CNT_W = $clog2(NUM_CHANNELS + 1);

    state_t                               r_state, w_state_next;
    logic                                 w_ev_ready;
    logic                                 r_ev_on;
    logic [PITCH_W-1:0]                   r_ev_pitch;
    wave_t                                r_ev_wave;
    logic [NUM_CHANNELS-1:0]              r_match, w_match;
    logic [IDX_W-1:0]                     r_free_idx, w_free_idx, w_match_idx;
    logic                                 r_none_free, w_none_free, w_any_match;
    logic [NUM_CHANNELS-1:0]              r_ena;
    logic [NUM_CHANNELS-1:0][PITCH_W-1:0] r_pitch;
    logic [NUM_CHANNELS-1:0][1:0]         r_wave;
    logic [NUM_CHANNELS-1:0][AGE_W-1:0]   r_age, w_aged;
    logic [CNT_W-1:0]                     r_count, w_popcount;
    logic                                 r_overflow;

`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0] r_old_idx, w_old_idx;

    voice_oldest_finder #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .AGE_W        (AGE_W)
    ) u_oldest (
        .i_ages (r_age),
        .o_idx  (w_old_idx)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ev_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ev_ready = 1'b1;
                if (ev.ev_valid) w_state_next = LOOKUP;
            end
            LOOKUP:  w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (all_off) w_state_next = IDLE;
    end

    always_comb begin
        w_free_idx  = '0;
        w_none_free = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++)
            w_match[i] = r_ena[i] && (r_pitch[i] == r_ev_pitch);
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (!r_ena[i]) begin
                w_free_idx  = IDX_W'(i);
                w_none_free = 1'b0;
            end
        end
    end

    // Retriggering keeps pitches unique, so the match vector is at most one-hot
    always_comb begin
        w_match_idx = '0;
        w_any_match = |r_match;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (r_match[i]) w_match_idx = IDX_W'(i);
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_popcount = w_popcount + CNT_W'(r_ena[i]);
            w_aged[i]  = (r_ena[i] && (r_age[i] != '1)) ? r_age[i] + 1'b1 : r_age[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ev_on     <= 1'b0;
            r_ev_pitch  <= '0;
            r_ev_wave   <= WAVE_SQUARE;
            r_match     <= '0;
            r_free_idx  <= '0;
            r_none_free <= 1'b0;
            r_ena       <= '0;
            r_pitch     <= '0;
            r_wave      <= '0;
            r_age       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
`ifdef VOICE_STEAL_EN
            r_old_idx   <= '0;
`endif
        end else begin
            r_count    <= w_popcount;
            r_overflow <= 1'b0;
            if (all_off) begin
                r_ena <= '0;
                r_age <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ev.ev_valid) begin
                            r_ev_on    <= ev.ev_on;
                            r_ev_pitch <= ev.ev_pitch;
                            r_ev_wave  <= ev.ev_wave;
                        end
                    end
                    LOOKUP: begin
                        r_match     <= w_match;
                        r_free_idx  <= w_free_idx;
                        r_none_free <= w_none_free;
`ifdef VOICE_STEAL_EN
                        r_old_idx   <= w_old_idx;
`endif
                    end
                    COMMIT: begin
                        if (r_ev_on && (r_ev_pitch != PITCH_W'(PITCH_ZERO))) begin
                            if (w_any_match) begin
                                r_age                <= w_aged;
                                r_age[w_match_idx]   <= '0;
                                r_wave[w_match_idx]  <= r_ev_wave;
                            end else if (!r_none_free) begin
                                r_age                <= w_aged;
                                r_ena[r_free_idx]    <= 1'b1;
                                r_pitch[r_free_idx]  <= r_ev_pitch;
                                r_wave[r_free_idx]   <= r_ev_wave;
                                r_age[r_free_idx]    <= '0;
                            end else begin
                                r_overflow <= 1'b1;
`ifdef VOICE_STEAL_EN
                                r_age               <= w_aged;
                                r_pitch[r_old_idx]  <= r_ev_pitch;
                                r_wave[r_old_idx]   <= r_ev_wave;
                                r_age[r_old_idx]    <= '0;
`endif
                            end
                        end else if (!r_ev_on && w_any_match) begin
                            r_ena[w_match_idx] <= 1'b0;
                            r_age[w_match_idx] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ev.ev_ready   = w_ev_ready;
    assign channel_ena   = r_ena;
    assign pitches       = r_pitch;
    assign waveforms     = r_wave;
    assign active_count  = r_count;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator with 4 channels
module tb_voice_allocator;

    localparam int NCH = 4;
    localparam int PW  = 12;

    logic          clk;
    logic          rst_n;
    logic          all_off;
    logic [NCH-1:0]    channel_ena;
    logic [NCH*PW-1:0] pitches;
    logic [NCH*2-1:0]  waveforms;
    logic [2:0]        active_count;
    logic              overflow;

    voice_allocator_if #(.PITCH_W(PW)) vif ();

    voice_allocator #(
        .NUM_CHANNELS (NCH),
        .PITCH_W      (PW),
        .AGE_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .ev           (vif),
        .all_off      (all_off),
        .channel_ena  (channel_ena),
        .pitches      (pitches),
        .waveforms    (waveforms),
        .active_count (active_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model of the channel table
    logic [NCH-1:0] m_ena;
    logic [PW-1:0]  m_pitch [NCH];
    logic [1:0]     m_wave  [NCH];
    int             m_age   [NCH];
    logic           last_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*PW-1:0] exp_pitches();
        logic [NCH*PW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*PW +: PW] = m_pitch[i];
        return r;
    endfunction

    function automatic logic [NCH*2-1:0] exp_waves();
        logic [NCH*2-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*2 +: 2] = m_wave[i];
        return r;
    endfunction

    task automatic model_reset();
        m_ena = '0;
        for (int i = 0; i < NCH; i++) begin
            m_pitch[i] = '0; m_wave[i] = '0; m_age[i] = 0;
        end
    endtask

    task automatic model_panic();
        m_ena = '0;
        for (int i = 0; i < NCH; i++) m_age[i] = 0;
    endtask

    task automatic age_up();
        for (int i = 0; i < NCH; i++)
            if (m_ena[i] && m_age[i] < 255) m_age[i]++;
    endtask

    task automatic model_event(input logic on, input logic [PW-1:0] p, input logic [1:0] w, output logic ovf);
        int hit = -1;
        int fr  = -1;
        ovf = 1'b0;
        for (int i = 0; i < NCH; i++) if (m_ena[i] && m_pitch[i] == p && hit < 0) hit = i;
        for (int i = 0; i < NCH; i++) if (!m_ena[i] && fr < 0) fr = i;
        if (!on) begin
            if (hit >= 0) begin m_ena[hit] = 1'b0; m_age[hit] = 0; end
        end else if (p != 0) begin
            if (hit >= 0) begin
                age_up(); m_age[hit] = 0; m_wave[hit] = w;
            end else if (fr >= 0) begin
                age_up(); m_ena[fr] = 1'b1; m_pitch[fr] = p; m_wave[fr] = w; m_age[fr] = 0;
            end else begin
                ovf = 1'b1;
`ifdef VOICE_STEAL_EN
                begin
                    int old = 0;
                    for (int i = 1; i < NCH; i++) if (m_age[i] > m_age[old]) old = i;
                    age_up(); m_pitch[old] = p; m_wave[old] = w; m_age[old] = 0;
                end
`endif
            end
        end
    endtask

    task automatic send(input logic on, input logic [PW-1:0] p, input logic [1:0] w);
        logic ovf;
        int   n = 0;
        @(negedge clk);
        while (vif.ev_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        check("ready_wait", 64'(vif.ev_ready), 64'd1);
        vif.ev_valid = 1'b1; vif.ev_on = on; vif.ev_pitch = p; vif.ev_wave = w;
        @(negedge clk);
        vif.ev_valid = 1'b0;
        @(negedge clk);
        check("no_early_ena", 64'(channel_ena), 64'(m_ena));
        @(negedge clk);
        model_event(on, p, w, ovf);
        last_ovf = overflow;
        check("ena", 64'(channel_ena), 64'(m_ena));
        check("pitches", 64'(pitches), 64'(exp_pitches()));
        check("waves", 64'(waveforms), 64'(exp_waves()));
        check("overflow", 64'(overflow), 64'(ovf));
        @(negedge clk);
        check("count", 64'(active_count), 64'($countones(m_ena)));
        check("overflow_1cyc", 64'(overflow), 64'd0);
    endtask

    typedef struct {
        logic           on;
        logic [PW-1:0]  pitch;
        logic [1:0]     wave;
        logic [NCH-1:0] exp_ena;
        logic           exp_ovf;
        int             exp_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_k [3];
        int nacc;
        int next_ok;
        logic [NCH-1:0] mask;
        logic ovf_dummy;

        tbl[0]  = '{1'b1, 12'd212, 2'd0, 4'b0001, 1'b0, 1};
        tbl[1]  = '{1'b1, 12'd106, 2'd1, 4'b0011, 1'b0, 2};
        tbl[2]  = '{1'b1, 12'd212, 2'd2, 4'b0011, 1'b0, 2};
        tbl[3]  = '{1'b0, 12'd106, 2'd0, 4'b0001, 1'b0, 1};
        tbl[4]  = '{1'b1, 12'd0,   2'd3, 4'b0001, 1'b0, 1};
        tbl[5]  = '{1'b0, 12'd999, 2'd0, 4'b0001, 1'b0, 1};
        tbl[6]  = '{1'b0, 12'd212, 2'd0, 4'b0000, 1'b0, 0};
        tbl[7]  = '{1'b1, 12'd100, 2'd0, 4'b0001, 1'b0, 1};
        tbl[8]  = '{1'b1, 12'd200, 2'd1, 4'b0011, 1'b0, 2};
        tbl[9]  = '{1'b1, 12'd300, 2'd2, 4'b0111, 1'b0, 3};
        tbl[10] = '{1'b1, 12'd400, 2'd3, 4'b1111, 1'b0, 4};
        tbl[11] = '{1'b1, 12'd500, 2'd0, 4'b1111, 1'b1, 4};
        tbl[12] = '{1'b0, 12'd200, 2'd0, 4'b1101, 1'b0, 3};
        tbl[13] = '{1'b1, 12'd600, 2'd1, 4'b1111, 1'b0, 4};

        rst_n = 1'b0; all_off = 1'b0;
        vif.ev_valid = 1'b0; vif.ev_on = 1'b0; vif.ev_pitch = '0; vif.ev_wave = '0;
        model_reset();
        last_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ena", 64'(channel_ena), 64'd0);
        check("rst_pitches", 64'(pitches), 64'd0);
        check("rst_waves", 64'(waveforms), 64'd0);
        check("rst_count", 64'(active_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(vif.ev_ready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            send(tbl[i].on, tbl[i].pitch, tbl[i].wave);
            check("tbl_ena", 64'(channel_ena), 64'(tbl[i].exp_ena));
            check("tbl_ovf", 64'(last_ovf), 64'(tbl[i].exp_ovf));
            check("tbl_cnt", 64'(active_count), 64'(tbl[i].exp_cnt));
            if (i == 2) check("retrig_wave", 64'(waveforms[1:0]), 64'd2);
            if (i == 13) check("reuse_ch1", 64'(pitches[PW +: PW]), 64'd600);
        end

        // all_off while a note-on is in LOOKUP
        @(negedge clk);
        vif.ev_valid = 1'b1; vif.ev_on = 1'b1; vif.ev_pitch = 12'd700; vif.ev_wave = 2'd3;
        @(negedge clk);
        vif.ev_valid = 1'b0; all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        model_panic();
        check("panic_ena", 64'(channel_ena), 64'd0);
        check("panic_ready", 64'(vif.ev_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("panic_discard_ena", 64'(channel_ena), 64'd0);
        check("panic_discard_pitch", 64'(pitches), 64'(exp_pitches()));
        check("panic_ovf", 64'(overflow), 64'd0);
        check("panic_count", 64'(active_count), 64'd0);

        // Continuous ev_valid: one acceptance per 3 cycles, effect visible 2 edges later
        vif.ev_valid = 1'b1; vif.ev_on = 1'b1; vif.ev_pitch = 12'd1000; vif.ev_wave = 2'd1;
        nacc = 0; next_ok = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (nacc > 0 && acc_k[nacc-1] == k - 1) begin
                vif.ev_pitch = PW'(1000 + nacc);
                if (nacc == 3) vif.ev_valid = 1'b0;
            end
            mask = '0;
            for (int j = 0; j < nacc; j++) if (k >= acc_k[j] + 3) mask[j] = 1'b1;
            check("hs_ena", 64'(channel_ena), 64'(mask));
            check("hs_ready", 64'(vif.ev_ready), 64'(k >= next_ok));
            if (vif.ev_valid && k >= next_ok) begin
                acc_k[nacc] = k; nacc++; next_ok = k + 3;
            end
        end
        for (int j = 0; j < 3; j++) model_event(1'b1, PW'(1000 + j), 2'd1, ovf_dummy);
        check("hs_pitches", 64'(pitches), 64'(exp_pitches()));
        check("hs_count", 64'(active_count), 64'd3);

        // Randomised events against the model
        for (int r = 0; r < 80; r++) begin
            send($urandom_range(0, 2) != 0, PW'($urandom_range(0, 6)), 2'($urandom_range(0, 3)));
        end

        // Reset asserted while COMMIT is pending
        send(1'b1, 12'd9, 2'd2);
        @(negedge clk);
        vif.ev_valid = 1'b1; vif.ev_on = 1'b1; vif.ev_pitch = 12'd77; vif.ev_wave = 2'd3;
        @(negedge clk);
        vif.ev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ena", 64'(channel_ena), 64'd0);
        check("arst_pitches", 64'(pitches), 64'd0);
        check("arst_waves", 64'(waveforms), 64'd0);
        check("arst_count", 64'(active_count), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        check("arst_ready", 64'(vif.ev_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send(1'b1, 12'd33, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Dynamic voice scheduler placed between note-event sources (key scanner, MIDI-style decoder, demo player) and channel_mixer.
- Shares the NUM_CHANNELS mixer channels among an unbounded set of requested notes: assigns note-on events to free channels, releases channels on note-off, and steals the oldest voice when all channels are busy.
- Drives the mixer's channel_ena, pitches and waveforms buses directly; the top-level selects between this block and the demo path.

Parameters:
- NUM_CHANNELS, 25, number of mixer channels (voices); legal 2..32.
- PITCH_W, 12, pitch word width; matches the mixer's per-channel pitch divider.
- AGE_W, 8, width of each per-channel age counter; saturates at all-ones.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- ev_valid  input  1  note event offered.
- ev_ready  output  1  block can accept an event this cycle.
- ev_on  input  1  1 = note-on, 0 = note-off.
- ev_pitch  input  PITCH_W  pitch divider of the note.
- ev_wave  input  2  waveform for a note-on; ignored for note-off.
- all_off  input  1  synchronous panic: release every channel.
- channel_ena  output  NUM_CHANNELS  per-channel enable to the mixer.
- pitches  output  NUM_CHANNELS*PITCH_W  packed; channel i at [i*PITCH_W +: PITCH_W].
- waveforms  output  NUM_CHANNELS*2  packed; channel i at [i*2 +: 2].
- active_count  output  $clog2(NUM_CHANNELS+1)  number of enabled channels.
- overflow  output  1  one-cycle pulse when a note-on could not get a free channel.

Behaviour:
- Reset (rst=0, asynchronous): channel_ena=0, pitches=0, waveforms=0, all ages=0, active_count=0, overflow=0, FSM=IDLE, ev_ready=1 after reset release.
- FSM states: IDLE, LOOKUP, COMMIT.
  - IDLE: ev_ready=1. On ev_valid&&ev_ready, capture ev_on/ev_pitch/ev_wave and go to LOOKUP.
  - LOOKUP: ev_ready=0. Register three results:
    - match vector: enabled channels whose pitch equals the captured pitch;
    - lowest-index free channel, plus a none-free flag;
    - oldest channel: maximum age, lowest index on ties.
    - Then go to COMMIT.
  - COMMIT: ev_ready=0. Apply the update below, then go to IDLE.
- Throughput and latency: one event per 3 cycles. Event accepted at edge N; outputs change at edge N+2.
- Note-on rules, first match wins:
  - ev_pitch==0: ignored; nothing changes.
  - Pitch already active: retrigger that channel. Its age goes to 0 and its waveform is updated to ev_wave. No new allocation.
  - A free channel exists: enable the lowest-index free channel and load pitch and waveform. Its age goes to 0.
  - No free channel: handled per the Optional Feature section.
  - On every accepted note-on, all other enabled channels increment their age, saturating at 2^AGE_W-1.
- Note-off rules:
  - Clear channel_ena on the matching channel; its age goes to 0.
  - Pitch and waveform registers keep their last values; the mixer output is silent via channel_ena.
  - No match: ignored.
- Duplicates: the retrigger rule guarantees at most one channel per pitch.
- all_off:
  - Sampled every cycle. When high: all channel_ena=0, all ages=0, FSM forced to IDLE, and any in-flight event is discarded.
  - all_off takes priority over a COMMIT in the same cycle.
- active_count: registered popcount of channel_ena, updated the cycle after channel_ena changes.
- overflow: asserted for exactly the COMMIT cycle's following clock (1 cycle). Otherwise 0.
- Reset mid-operation: async clear as above; any in-flight event is lost.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a note-on with no free channel steals the oldest channel (LOOKUP result). The channel gets the new pitch and waveform, its age goes to 0, and it stays enabled. overflow pulses.
- Undefined: a note-on with no free channel is dropped; no channel state changes. overflow pulses. No age comparator logic is built; age counters are still kept for retrigger and stealing parity.

Decomposition:
- Package voice_pkg:
  - typedef state_t {IDLE, LOOKUP, COMMIT};
  - typedef wave_t logic[1:0] (SQUARE, SAW, TRIANGLE, SINE encodings shared with get_waveform);
  - localparam PITCH_ZERO.
- Sub-module voice_oldest_finder: combinational/registered max-age search with lowest-index tie-break. Parameterised on NUM_CHANNELS and AGE_W; instantiated only under VOICE_STEAL_EN.

Test Plan (NUM_CHANNELS=4):
- Reset, then note-on 212 then note-on 106 -> channel_ena=4'b0011, pitches ch0=212, ch1=106; active_count=2 two cycles after the second COMMIT.
- Note-on 212 twice, second with ev_wave=2 -> channel_ena=4'b0001, ch0 waveform=2, active_count=1, no overflow.
- Fill 4 channels (100,200,300,400), then note-on 500:
  - with VOICE_STEAL_EN -> ch0 pitch=500, overflow pulses 1 cycle, channel_ena=4'b1111;
  - without it -> pitches unchanged, overflow pulses.
- Note-off 200 with 4 voices active -> channel_ena=4'b1101. A following note-on 600 -> lands in ch1.
- Handshake: hold ev_valid=1 continuously -> ev_ready high 1 of every 3 cycles; each event takes effect exactly 2 edges after its acceptance.
- Assert all_off during LOOKUP of a note-on -> channel_ena=0 next cycle, event discarded, ev_ready=1. Drive rst=0 mid-COMMIT -> all outputs 0 immediately, no clock needed.
